dflow_tuple_gen: RTL
====================

DFLOW_TUPLE_GEN -- requirements
Module: dflow_tuple_gen

Interface
REQ-001 SHALL have parameter NUM_FLOWS, default 16, meaning the number of distinct flows cycled, a power of 2 from 2 to 65536.
REQ-002 SHALL have parameter LEN_W, default 16, meaning the packet-length field width.
REQ-003 SHALL have parameter TUPLE_W, default 104, meaning the 5-tuple width; this value is fixed.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; resetn  in  1  async active-low reset.
REQ-005 SHALL have register-bus inputs: reg_req  in  1  one-cycle request pulse; reg_rd_wr_L  in  1  1=read, 0=write.
REQ-006 SHALL have further register-bus inputs: reg_addr  in  32  byte address, bits [5:0] decoded; reg_wr_data  in  32  write data.
REQ-007 SHALL have register-bus outputs: reg_ack  out  1  completion pulse; reg_rd_data  out  32  read data.
REQ-008 SHALL have tuple outputs: five_tuple_data_out  out  TUPLE_W  {src_ip[103:72], dst_ip[71:40], src_port[39:24], dst_port[23:8], proto[7:0]}; pkt_len_out  out  LEN_W  packet length.
REQ-009 SHALL have the output handshake pair: tuple_out_vld  out  1  output valid; tuple_out_ready  in  1  consumer ready.

Function
REQ-010 SHALL assert reg_ack for exactly one cycle, in cycle T+1, for a reg_req in cycle T; reg_rd_data SHALL be valid in that cycle and 0 otherwise.
REQ-011 SHALL implement this register map: 0x00 CTRL[0]=enable, [2:1]=mode (00 seq, 01 random, 10 fixed); 0x04 SRC_IP; 0x08 DST_IP; 0x0C PORTS {src[31:16], dst[15:0]}; 0x10 PROTO[7:0]; 0x14 LEN {max[31:16], min[15:0]}; 0x18 PKT_TARGET (0 = unlimited).
REQ-012 SHALL implement read-only registers 0x1C SENT_CNT and 0x20 STATUS {done[2], state[1:0]}; writes to them SHALL be ignored, unmapped reads SHALL return 0, and mode 11 SHALL behave as fixed.
REQ-013 SHALL use an FSM with states IDLE(00), RUN(01), DONE(10): IDLE->RUN when enable=1; RUN->DONE when PKT_TARGET!=0 and SENT_CNT reaches PKT_TARGET on a handshake; RUN->IDLE when enable=0 and no output is pending; DONE->IDLE when enable=0.
REQ-014 SHALL, for an enable write whose req is in cycle T while in IDLE, clear SENT_CNT and raise tuple_out_vld in cycle T+2.
REQ-015 SHALL count a handshake as a cycle with tuple_out_vld=1 and tuple_out_ready=1; SENT_CNT SHALL increment by 1 per handshake and saturate at 0xFFFFFFFF.
REQ-016 SHALL hold tuple_out_vld, five_tuple_data_out and pkt_len_out stable while vld=1 and ready=0, including across config writes and enable=0.
REQ-017 SHALL, on a handshake in RUN when not entering DONE, present the next tuple in the following cycle; this sustains 1 tuple/cycle at ready=1.
REQ-018 SHALL compute the flow index idx as follows: seq mode, 0,1,..,NUM_FLOWS-1 then wrap to 0; random mode, LFSR[log2(NUM_FLOWS)-1:0]; fixed mode, 0.
REQ-019 SHALL form the tuple as src_ip=SRC_IP+idx and dst_port=DST_PORT+idx, both modulo 2^32 and 2^16, with the other fields taken from registers unchanged.
REQ-020 SHALL generate pkt_len as follows: seq mode, starts at min and adds 1 per handshake, wrapping from max to min; random and fixed modes, min; if min>=max, always min.
REQ-021 SHALL use a 32-bit Galois LFSR with taps x^32+x^22+x^2+x+1, seeded 0x00000001, advancing only on handshakes in random mode.
REQ-022 SHALL drive tuple_out_vld=0 in IDLE and DONE, and SHALL restart idx and length at 0/min on each IDLE->RUN transition.
REQ-023 SHALL, on a simultaneous reg write and handshake, apply the new register values to the next tuple after the current one.

Reset
REQ-024 SHALL, while resetn=0, asynchronously force: state=IDLE, all config registers=0, SENT_CNT=0, LFSR=0x00000001, reg_ack=0, reg_rd_data=0, tuple_out_vld=0, five_tuple_data_out=0, pkt_len_out=0.
REQ-025 SHALL discard any pending tuple on reset assertion mid-run and SHALL not raise vld after deassertion until enable is written.

Structure
REQ-026 SHALL place register offsets, mode encodings, FSM state encodings and tuple field bit positions in the shared package dflow_gen_pkg.
REQ-027 SHALL implement the LFSR as the sub-module dflow_lfsr, with ports clk, resetn, advance and state[31:0].

Verification
REQ-028 Seq run: SRC_IP=0x0A000000, DST_PORT=80, LEN=0x0042_0040, TARGET=5, enable, ready=1 -> 5 tuples with src_ip ...00..04, dst_port 80..84, len 64,65,66,64,65; then STATUS.done=1 and SENT_CNT=5.
REQ-029 Backpressure: hold ready=0 for 10 cycles mid-run while writing SRC_IP -> output bit-stable during the stall; the new SRC_IP appears on the tuple after the stalled one.
REQ-030 Wrap: NUM_FLOWS=4, seq, TARGET=0, 9 handshakes -> idx sequence 0,1,2,3,0,1,2,3,0.
REQ-031 Random: mode=01, NUM_FLOWS=16 -> idx sequence equals a reference LFSR model seeded 1 and advanced per handshake.
REQ-032 Disable and reset: write enable=0 with vld=1 and ready=0 -> vld held until handshake, then IDLE; assert resetn=0 mid-run -> all outputs 0 immediately.
REQ-033 Register bus: read 0x24 -> ack at T+1 with data 0; write 0x1C -> SENT_CNT unchanged.

Source files
------------

// File: rtl/dflow_gen_pkg.sv
// Shared definitions for the dataflow 5-tuple generator: register map, mode and
// FSM encodings, tuple field positions and the LFSR step function.
package dflow_gen_pkg;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_SRC_IP   = 6'h04;
    localparam logic [5:0] OFF_DST_IP   = 6'h08;
    localparam logic [5:0] OFF_PORTS    = 6'h0C;
    localparam logic [5:0] OFF_PROTO    = 6'h10;
    localparam logic [5:0] OFF_LEN      = 6'h14;
    localparam logic [5:0] OFF_TARGET   = 6'h18;
    localparam logic [5:0] OFF_SENT_CNT = 6'h1C;
    localparam logic [5:0] OFF_STATUS   = 6'h20;

    localparam logic [1:0] MODE_SEQ   = 2'b00;
    localparam logic [1:0] MODE_RAND  = 2'b01;
    localparam logic [1:0] MODE_FIXED = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int TUPLE_BITS   = 104;
    localparam int SRC_IP_MSB   = 103;
    localparam int SRC_IP_LSB   = 72;
    localparam int DST_IP_MSB   = 71;
    localparam int DST_IP_LSB   = 40;
    localparam int SRC_PORT_MSB = 39;
    localparam int SRC_PORT_LSB = 24;
    localparam int DST_PORT_MSB = 23;
    localparam int DST_PORT_LSB = 8;
    localparam int PROTO_MSB    = 7;
    localparam int PROTO_LSB    = 0;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/dflow_lfsr.sv
// 32-bit Galois LFSR that steps once per cycle when advance is high.
module dflow_lfsr
    import dflow_gen_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] r_state;

    // LFSR state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= LFSR_SEED;
        end else if (advance) begin
            r_state <= lfsr_step(r_state);
        end else begin
            r_state <= r_state;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/dflow_tuple_gen.sv
// Synthetic 5-tuple traffic generator with a register bus and valid/ready output.
// Tuples are built from the next-cycle config values so a write landing with a handshake shapes the next tuple.
module dflow_tuple_gen
    import dflow_gen_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int LEN_W     = 16,
    parameter int TUPLE_W   = 104
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               reg_req,
    input  logic               reg_rd_wr_L,
    input  logic [31:0]        reg_addr,
    input  logic [31:0]        reg_wr_data,
    output logic               reg_ack,
    output logic [31:0]        reg_rd_data,
    output logic [TUPLE_W-1:0] five_tuple_data_out,
    output logic [LEN_W-1:0]   pkt_len_out,
    output logic               tuple_out_vld,
    input  logic               tuple_out_ready
);

    localparam int IDX_W = $clog2(NUM_FLOWS);

    logic               r_enable;
    logic [1:0]         r_mode;
    logic [31:0]        r_src_ip;
    logic [31:0]        r_dst_ip;
    logic [15:0]        r_src_port;
    logic [15:0]        r_dst_port;
    logic [7:0]         r_proto;
    logic [15:0]        r_len_min;
    logic [15:0]        r_len_max;
    logic [31:0]        r_target;
    logic [31:0]        r_sent_cnt;
    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [15:0]        r_cur_len;
    logic               r_vld;
    logic [TUPLE_W-1:0] r_tuple;
    logic [LEN_W-1:0]   r_len_out;
    logic               r_ack;
    logic [31:0]        r_rd_data;

    logic               w_wr;
    logic               w_rd;
    logic [5:0]         w_off;
    logic               w_unused_ok;
    logic               w_enable_nx;
    logic [1:0]         w_mode_nx;
    logic [31:0]        w_src_ip_nx;
    logic [31:0]        w_dst_ip_nx;
    logic [15:0]        w_src_port_nx;
    logic [15:0]        w_dst_port_nx;
    logic [7:0]         w_proto_nx;
    logic [15:0]        w_len_min_nx;
    logic [15:0]        w_len_max_nx;
    logic [31:0]        w_target_nx;
    logic               w_hs;
    logic [31:0]        w_cnt_inc;
    logic               w_target_hit;
    state_e             w_state_nx;
    logic               w_load;
    logic               w_start;
    logic               w_vld_nx;
    logic               w_lfsr_adv;
    logic [31:0]        w_lfsr_state;
    logic [31:0]        w_lfsr_step;
    logic [IDX_W-1:0]   w_idx_nx;
    logic [15:0]        w_len_nx;
    logic [TUPLE_BITS-1:0] w_tuple_nx;
    logic [31:0]        w_rd_mux;

    assign w_wr        = reg_req & ~reg_rd_wr_L;
    assign w_rd        = reg_req & reg_rd_wr_L;
    assign w_off       = reg_addr[5:0];
    assign w_unused_ok = ^reg_addr[31:6];

    assign w_enable_nx   = (w_wr && w_off == OFF_CTRL)   ? reg_wr_data[0]     : r_enable;
    assign w_mode_nx     = (w_wr && w_off == OFF_CTRL)   ? reg_wr_data[2:1]   : r_mode;
    assign w_src_ip_nx   = (w_wr && w_off == OFF_SRC_IP) ? reg_wr_data        : r_src_ip;
    assign w_dst_ip_nx   = (w_wr && w_off == OFF_DST_IP) ? reg_wr_data        : r_dst_ip;
    assign w_src_port_nx = (w_wr && w_off == OFF_PORTS)  ? reg_wr_data[31:16] : r_src_port;
    assign w_dst_port_nx = (w_wr && w_off == OFF_PORTS)  ? reg_wr_data[15:0]  : r_dst_port;
    assign w_proto_nx    = (w_wr && w_off == OFF_PROTO)  ? reg_wr_data[7:0]   : r_proto;
    assign w_len_max_nx  = (w_wr && w_off == OFF_LEN)    ? reg_wr_data[31:16] : r_len_max;
    assign w_len_min_nx  = (w_wr && w_off == OFF_LEN)    ? reg_wr_data[15:0]  : r_len_min;
    assign w_target_nx   = (w_wr && w_off == OFF_TARGET) ? reg_wr_data        : r_target;

    assign w_hs         = r_vld & tuple_out_ready;
    assign w_cnt_inc    = (r_sent_cnt == 32'hFFFF_FFFF) ? r_sent_cnt : r_sent_cnt + 32'd1;
    assign w_target_hit = (r_target != 32'd0) && (w_cnt_inc == r_target);
    assign w_lfsr_adv   = w_hs & (w_mode_nx == MODE_RAND);
    assign w_lfsr_step  = lfsr_step(w_lfsr_state);

    dflow_lfsr u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .advance (w_lfsr_adv),
        .state   (w_lfsr_state)
    );

    // Configuration registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_enable   <= 1'b0;
            r_mode     <= 2'b00;
            r_src_ip   <= 32'd0;
            r_dst_ip   <= 32'd0;
            r_src_port <= 16'd0;
            r_dst_port <= 16'd0;
            r_proto    <= 8'd0;
            r_len_min  <= 16'd0;
            r_len_max  <= 16'd0;
            r_target   <= 32'd0;
        end else begin
            r_enable   <= w_enable_nx;
            r_mode     <= w_mode_nx;
            r_src_ip   <= w_src_ip_nx;
            r_dst_ip   <= w_dst_ip_nx;
            r_src_port <= w_src_port_nx;
            r_dst_port <= w_dst_port_nx;
            r_proto    <= w_proto_nx;
            r_len_min  <= w_len_min_nx;
            r_len_max  <= w_len_max_nx;
            r_target   <= w_target_nx;
        end
    end

    // FSM next state, tuple-load strobes and next valid
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_start    = 1'b0;
        w_vld_nx   = r_vld;
        case (r_state)
            ST_IDLE: begin
                if (r_enable) begin
                    w_state_nx = ST_RUN;
                    w_start    = 1'b1;
                    w_load     = 1'b1;
                    w_vld_nx   = 1'b1;
                end else begin
                    w_vld_nx   = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_hs && w_target_hit) begin
                    w_state_nx = ST_DONE;
                    w_vld_nx   = 1'b0;
                end else if (!r_enable && (w_hs || !r_vld)) begin
                    w_state_nx = ST_IDLE;
                    w_vld_nx   = 1'b0;
                end else if (w_hs) begin
                    w_load     = 1'b1;
                    w_vld_nx   = 1'b1;
                end else begin
                    w_vld_nx   = r_vld;
                end
            end
            ST_DONE: begin
                w_vld_nx = 1'b0;
                if (!r_enable) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_vld_nx   = 1'b0;
            end
        endcase
    end

    // Flow index, packet length and tuple for the next load
    always_comb begin
        w_idx_nx = '0;
        case (w_mode_nx)
            MODE_SEQ:  w_idx_nx = w_start ? '0 : r_idx + IDX_W'(1);
            MODE_RAND: w_idx_nx = w_start ? w_lfsr_state[IDX_W-1:0] : w_lfsr_step[IDX_W-1:0];
            default:   w_idx_nx = '0;
        endcase

        // Out-of-window current length (min/max rewritten mid-run) restarts at min.
        if (w_mode_nx == MODE_SEQ && !w_start && w_len_min_nx < w_len_max_nx
            && r_cur_len >= w_len_min_nx && r_cur_len < w_len_max_nx) begin
            w_len_nx = r_cur_len + 16'd1;
        end else begin
            w_len_nx = w_len_min_nx;
        end

        w_tuple_nx = '0;
        w_tuple_nx[SRC_IP_MSB:SRC_IP_LSB]     = w_src_ip_nx + 32'(w_idx_nx);
        w_tuple_nx[DST_IP_MSB:DST_IP_LSB]     = w_dst_ip_nx;
        w_tuple_nx[SRC_PORT_MSB:SRC_PORT_LSB] = w_src_port_nx;
        w_tuple_nx[DST_PORT_MSB:DST_PORT_LSB] = w_dst_port_nx + 16'(w_idx_nx);
        w_tuple_nx[PROTO_MSB:PROTO_LSB]       = w_proto_nx;
    end

    // State register and sent counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sent_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_sent_cnt <= 32'd0;
            end else if (w_hs) begin
                r_sent_cnt <= w_cnt_inc;
            end else begin
                r_sent_cnt <= r_sent_cnt;
            end
        end
    end

    // Output tuple registers; held whenever no load occurs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld     <= 1'b0;
            r_tuple   <= '0;
            r_len_out <= '0;
            r_cur_len <= 16'd0;
            r_idx     <= '0;
        end else begin
            r_vld <= w_vld_nx;
            if (w_load) begin
                r_tuple   <= TUPLE_W'(w_tuple_nx);
                r_len_out <= LEN_W'(w_len_nx);
                r_cur_len <= w_len_nx;
                r_idx     <= w_idx_nx;
            end else begin
                r_tuple   <= r_tuple;
                r_len_out <= r_len_out;
                r_cur_len <= r_cur_len;
                r_idx     <= r_idx;
            end
        end
    end

    // Register read multiplexer
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            OFF_CTRL:     w_rd_mux = {29'd0, r_mode, r_enable};
            OFF_SRC_IP:   w_rd_mux = r_src_ip;
            OFF_DST_IP:   w_rd_mux = r_dst_ip;
            OFF_PORTS:    w_rd_mux = {r_src_port, r_dst_port};
            OFF_PROTO:    w_rd_mux = {24'd0, r_proto};
            OFF_LEN:      w_rd_mux = {r_len_max, r_len_min};
            OFF_TARGET:   w_rd_mux = r_target;
            OFF_SENT_CNT: w_rd_mux = r_sent_cnt;
            OFF_STATUS:   w_rd_mux = {29'd0, (r_state == ST_DONE), r_state};
            default:      w_rd_mux = 32'd0;
        endcase
    end

    // Bus response: ack one cycle after every request, data only for reads
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ack     <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            r_ack     <= reg_req;
            r_rd_data <= w_rd ? w_rd_mux : 32'd0;
        end
    end

    assign reg_ack             = r_ack;
    assign reg_rd_data         = r_rd_data;
    assign tuple_out_vld       = r_vld;
    assign five_tuple_data_out = r_tuple;
    assign pkt_len_out         = r_len_out;

endmodule
